// File: rtl/keylock_machine_param.sv
// Parametrised code lock: DIGITS keys of DIGIT_W bits, failed-attempt lockout, length checking.
// Optional inactivity timeout enabled by defining KEYLOCK_ENTRY_TIMEOUT_EN.
module keylock_machine_param #(
  parameter int DIGITS         = 5,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clock,
  input  logic                        in_reset_n,
  input  logic [DIGIT_W-1:0]          in_key,
  input  logic                        in_acc,
  input  logic                        in_start,
  input  logic                        in_finish,
  output logic                        ou_closed,
  output logic                        ou_error,
  output logic                        ou_locked_out,
  output logic [2:0]                  ou_state,
  output logic [$clog2(DIGITS+1)-1:0] ou_count,
  output logic [DIGITS*DIGIT_W-1:0]   ou_entry
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int BW = DIGITS*DIGIT_W;
  localparam int FW = $clog2(MAX_TRIES+1);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    S_UNSET   = 3'd0,
    S_PROGRAM = 3'd1,
    S_CLOSED  = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d, code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fail_q, fail_d, fail_inc;
  logic [LW-1:0]   lock_q, lock_d;
  logic            ovf_q, ovf_d, err_q, err_d, from_open_q, from_open_d;
  logic            clr, shift, full, match;

  // Button sample pipeline, bit order {start, finish, acc}; idle level is 1.
  logic [2:0] smp_q, prv_q, raw;
  logic       ev_start, ev_fin, ev_acc, any_ev;

  always_ff @(posedge clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      smp_q <= '1;
      prv_q <= '1;
    end else begin
      smp_q <= {in_start, in_finish, in_acc};
      prv_q <= smp_q;
    end
  end

  assign raw      = prv_q & ~smp_q;
  assign any_ev   = |raw;
  assign ev_start = raw[2];
  assign ev_fin   = raw[1] & ~raw[2];
  assign ev_acc   = raw[0] & ~raw[1] & ~raw[2];

  assign full     = (cnt_q == CW'(DIGITS));
  assign match    = full && !ovf_q && (buf_q == code_q);
  assign fail_inc = fail_q + 1'b1;

`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmo_q;
  logic          tmo_run, tmo_fire;

  assign tmo_run  = (state_q == S_PROGRAM) || ((state_q == S_CLOSED) && (cnt_q != '0));
  assign tmo_fire = tmo_run && !any_ev && (tmo_q == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clock or negedge in_reset_n) begin
    if (!in_reset_n)                     tmo_q <= '0;
    else if (!tmo_run || any_ev || tmo_fire) tmo_q <= '0;
    else                                 tmo_q <= tmo_q + 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    code_d      = code_q;
    fail_d      = fail_q;
    lock_d      = lock_q;
    err_d       = err_q;
    from_open_d = from_open_q;
    clr         = 1'b0;
    shift       = 1'b0;
    case (state_q)
      S_UNSET: begin
        if (ev_start) begin
          state_d = S_PROGRAM; from_open_d = 1'b0; clr = 1'b1; err_d = 1'b0;
        end else if (ev_acc) err_d = 1'b0;
      end
      S_PROGRAM: begin
        if (ev_start) begin
          clr = 1'b1; err_d = 1'b0;
        end else if (ev_fin) begin
          clr = 1'b1;
          if (full && !ovf_q) begin
            code_d = buf_q; state_d = S_CLOSED;
          end else begin
            err_d = 1'b1; state_d = from_open_q ? S_OPEN : S_UNSET;
          end
        end else if (ev_acc) begin
          shift = 1'b1; err_d = 1'b0;
        end
      end
      S_CLOSED: begin
        if (ev_start) begin
          clr = 1'b1; err_d = 1'b0;
        end else if (ev_fin) begin
          clr = 1'b1;
          if (match) begin
            state_d = S_OPEN; fail_d = '0;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc >= FW'(MAX_TRIES)) begin
              state_d = S_LOCKOUT; lock_d = LW'(LOCKOUT_CYCLES-1);
            end
          end
        end else if (ev_acc) begin
          shift = 1'b1; err_d = 1'b0;
        end
      end
      S_OPEN: begin
        if (ev_start) begin
          state_d = S_PROGRAM; from_open_d = 1'b1; clr = 1'b1; err_d = 1'b0;
        end else if (ev_fin) begin
          state_d = S_CLOSED; clr = 1'b1;
        end else if (ev_acc) err_d = 1'b0;
      end
      S_LOCKOUT: begin
        // Buttons are deliberately ignored here; only the countdown matters.
        if (lock_q == '0) begin
          state_d = S_CLOSED; fail_d = '0; err_d = 1'b0; clr = 1'b1;
        end else lock_d = lock_q - 1'b1;
      end
      default: state_d = S_UNSET;
    endcase

    if (shift) begin
      buf_d = {buf_q[BW-DIGIT_W-1:0], in_key};
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end
    if (clr) begin
      buf_d = '0; cnt_d = '0; ovf_d = 1'b0;
    end
`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
    if (tmo_fire) begin
      buf_d = '0; cnt_d = '0; ovf_d = 1'b0; err_d = 1'b1;
      if (state_q == S_PROGRAM) state_d = from_open_q ? S_OPEN : S_UNSET;
    end
`endif
  end

  always_ff @(posedge clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= S_UNSET;
      buf_q       <= '0;
      code_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      fail_q      <= '0;
      lock_q      <= '0;
      err_q       <= 1'b0;
      from_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      fail_q      <= fail_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      from_open_q <= from_open_d;
    end
  end

  assign ou_state      = state_q;
  assign ou_closed     = (state_q == S_CLOSED) || (state_q == S_LOCKOUT);
  assign ou_locked_out = (state_q == S_LOCKOUT);
  assign ou_error      = err_q;
  assign ou_count      = cnt_q;
  assign ou_entry      = buf_q;
endmodule
